exec_monitor: RTL and testbench

//  Synthesizable run monitor for the RISC-V data_path, replacing fixed-delay

---
 rtl/exec_monitor.sv | 150 +++++++++++++++
 tb/tb_exec_monitor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/exec_monitor.sv
// ============================================================================
// Module      : exec_monitor
// Description : Run monitor for the RISC-V data_path. It detects halt or
//               timeout, counts cycles and writebacks, and shadows a window
//               of data memory as the result signature.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module exec_monitor #(
   parameter int                XLEN        = 32,
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] SIG_BASE    = '0,
   parameter int                SIG_WORDS   = 8,
   parameter int                IDX_W       = (SIG_WORDS > 1) ? $clog2(SIG_WORDS) : 1,
   parameter int                HALT_STABLE = 4,
   parameter int                MAX_CYCLES  = 4000,
   parameter int                CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run_en,
   input  logic              clear,
   input  logic [XLEN-1:0]   pc,
   input  logic              rf_we,
   input  logic [4:0]        rf_rd,
   input  logic [XLEN-1:0]   rf_wdata,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [XLEN-1:0]   dm_wdata,
   input  logic [IDX_W-1:0]  sig_idx,
   output logic [XLEN-1:0]   sig_data,
   output logic              running,
   output logic              done,
   output logic              timeout,
   output logic [CNT_W-1:0]  cycles,
   output logic [CNT_W-1:0]  wb_count,
   output logic [XLEN-1:0]   wb_xor,
   output logic [XLEN-1:0]   halt_pc
);

   localparam int              c_DEPTH  = 1 << IDX_W;
   localparam int              c_STB_W  = $clog2(HALT_STABLE + 1);
   // Window bounds carry one extra bit so the upper bound cannot wrap.
   localparam logic [ADDR_W:0] c_SIG_LO = {1'b0, SIG_BASE};
   localparam logic [ADDR_W:0] c_SIG_HI = c_SIG_LO + (ADDR_W+1)'(SIG_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_DONE    = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [XLEN-1:0]     r_pc_prev;
   logic [c_STB_W-1:0]  r_stable;
   logic [CNT_W-1:0]    r_cycles;
   logic [CNT_W-1:0]    r_wb_count;
   logic [XLEN-1:0]     r_wb_xor;
   logic [XLEN-1:0]     r_halt_pc;
   logic [XLEN-1:0]     r_shadow [c_DEPTH];

   logic                w_run;
   logic                w_counted;
   logic                w_halt;
   logic                w_limit;
   logic                w_wb;
   logic                w_in_win;
   logic [IDX_W-1:0]    w_idx;

   assign w_run     = (r_state == ST_RUN);
   // A zero cycle count marks the first RUN cycle, where pc_prev is stale.
   assign w_counted = w_run && (r_cycles != '0) && (pc == r_pc_prev);
   assign w_halt    = w_counted && (r_stable == c_STB_W'(HALT_STABLE - 1));
   assign w_limit   = w_run && (r_cycles == CNT_W'(MAX_CYCLES - 1));
   assign w_wb      = w_run && rf_we && (rf_rd != 5'd0);
   assign w_in_win  = w_run && dm_we && ({1'b0, dm_addr} >= c_SIG_LO)
                                     && ({1'b0, dm_addr} <  c_SIG_HI);
   assign w_idx     = IDX_W'(dm_addr - SIG_BASE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (run_en) w_state_nxt = ST_RUN;
            ST_RUN: begin
               if (w_halt)       w_state_nxt = ST_DONE;
               else if (w_limit) w_state_nxt = ST_TIMEOUT;
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc_prev  <= '0;
         r_stable   <= '0;
         r_cycles   <= '0;
         r_wb_count <= '0;
         r_wb_xor   <= '0;
         r_halt_pc  <= '0;
         for (int i = 0; i < c_DEPTH; i++) r_shadow[i] <= '0;
      end else if (clear) begin
         r_pc_prev  <= '0;
         r_stable   <= '0;
         r_cycles   <= '0;
         r_wb_count <= '0;
         r_wb_xor   <= '0;
         r_halt_pc  <= '0;
         for (int i = 0; i < c_DEPTH; i++) r_shadow[i] <= '0;
      end else if (w_run) begin
         r_pc_prev <= pc;
         if (r_cycles != '1) r_cycles <= r_cycles + 1'b1;
         if (w_counted) r_stable <= r_stable + 1'b1;
         else           r_stable <= '0;
         if (w_halt) r_halt_pc <= pc;
         if (w_wb) begin
            if (r_wb_count != '1) r_wb_count <= r_wb_count + 1'b1;
            r_wb_xor <= r_wb_xor ^ rf_wdata;
         end
         if (w_in_win) r_shadow[w_idx] <= dm_wdata;
      end
   end

   always_comb begin
      sig_data = '0;
      if (int'(sig_idx) < SIG_WORDS) sig_data = r_shadow[sig_idx];
   end

   assign running  = (r_state == ST_RUN);
   assign done     = (r_state == ST_DONE);
   assign timeout  = (r_state == ST_TIMEOUT);
   assign cycles   = r_cycles;
   assign wb_count = r_wb_count;
   assign wb_xor   = r_wb_xor;
   assign halt_pc  = r_halt_pc;

endmodule

`default_nettype wire

// File: tb/tb_exec_monitor.sv
// ============================================================================
// Module      : tb_exec_monitor
// Description : Directed self-checking bench for exec_monitor.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_exec_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        run_en, clear;
   logic [31:0] pc, rf_wdata, dm_addr, dm_wdata;
   logic        rf_we, dm_we;
   logic [4:0]  rf_rd;
   logic [2:0]  sig_idx;
   logic [31:0] sig_data, cycles, wb_count, wb_xor, halt_pc;
   logic        running, done, timeout;

   int n_vec = 0;
   int n_err = 0;

   exec_monitor #(
      .XLEN(32), .ADDR_W(32), .SIG_BASE(32'h100), .SIG_WORDS(8),
      .HALT_STABLE(4), .MAX_CYCLES(16), .CNT_W(32)
   ) dut (
      .clk(clk), .rst(rst), .run_en(run_en), .clear(clear), .pc(pc),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
      .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .sig_idx(sig_idx), .sig_data(sig_data),
      .running(running), .done(done), .timeout(timeout),
      .cycles(cycles), .wb_count(wb_count), .wb_xor(wb_xor), .halt_pc(halt_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run();
      run_en = 1'b1;
      tick();
      run_en = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      rst = 1'b0; run_en = 1'b0; clear = 1'b0; pc = '0;
      rf_we = 1'b0; rf_rd = '0; rf_wdata = '0;
      dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; sig_idx = '0;

      // Reset state
      #3;
      check("rst_running", running, 0);
      check("rst_done",    done,    0);
      check("rst_timeout", timeout, 0);
      check("rst_cycles",  cycles,  0);
      tick(); tick();
      rst = 1'b1;
      tick();
      check("idle_no_run", running, 0);

      // Halt on PC self-loop: 0,4,8,C then C held
      start_run();
      check("t1_running", running, 1);
      for (int i = 0; i < 8; i++) begin
         pc = (i < 3) ? 32'(4 * i) : 32'hC;
         tick();
         if (i == 6) check("t1_done_early", done, 0);
      end
      check("t1_done",    done,    1);
      check("t1_running", running, 0);
      check("t1_halt_pc", halt_pc, 32'hC);
      check("t1_cycles",  cycles,  8);
      check("t1_timeout", timeout, 0);

      do_clear();
      check("clr_done",    done,    0);
      check("clr_cycles",  cycles,  0);
      check("clr_halt_pc", halt_pc, 0);

      // Writebacks and signature writes, then run on into timeout
      start_run();
      pc = 32'h0; rf_we = 1'b1; rf_rd = 5'd5; rf_wdata = 32'h11;
      dm_we = 1'b1; dm_addr = 32'h102; dm_wdata = 32'hAB;
      tick();
      pc = 32'h4; rf_rd = 5'd0; rf_wdata = 32'hFF;
      dm_addr = 32'h108; dm_wdata = 32'hCD;
      tick();
      pc = 32'h8; rf_rd = 5'd6; rf_wdata = 32'h22;
      dm_addr = 32'hFF; dm_wdata = 32'hEE;
      tick();
      pc = 32'hC; rf_we = 1'b0; dm_we = 1'b0;
      tick();
      check("t3_wb_count", wb_count, 2);
      check("t3_wb_xor",   wb_xor,   32'h33);
      check("t3_cycles",   cycles,   4);
      sig_idx = 3'd2; #1;
      check("t4_sig2", sig_data, 32'hAB);
      sig_idx = 3'd0; #1;
      check("t4_sig0_above_win", sig_data, 0);
      sig_idx = 3'd7; #1;
      check("t4_sig7_below_win", sig_data, 0);

      for (int i = 4; i < 16; i++) begin
         pc = 32'(4 * i);
         tick();
         if (i == 14) check("t2_timeout_early", timeout, 0);
      end
      check("t2_timeout", timeout, 1);
      check("t2_cycles",  cycles,  16);
      check("t2_done",    done,    0);
      rf_we = 1'b1; rf_rd = 5'd7; rf_wdata = 32'h44;
      tick();
      rf_we = 1'b0;
      check("frz_wb_count", wb_count, 2);
      check("frz_cycles",   cycles,   16);
      sig_idx = 3'd2; #1;
      check("frz_sig2", sig_data, 32'hAB);

      // Halt completes on the same edge the timeout limit is reached
      do_clear();
      check("clr_timeout", timeout, 0);
      start_run();
      for (int i = 0; i < 16; i++) begin
         pc = (i <= 11) ? 32'(4 * i) : 32'h2C;
         tick();
         if (i == 14) check("t5_done_early", done, 0);
      end
      check("t5_done",    done,    1);
      check("t5_timeout", timeout, 0);
      check("t5_halt_pc", halt_pc, 32'h2C);
      check("t5_cycles",  cycles,  16);

      // Asynchronous reset mid-run
      do_clear();
      start_run();
      rf_we = 1'b1; rf_rd = 5'd3; rf_wdata = 32'h5A;
      dm_we = 1'b1; dm_addr = 32'h102; dm_wdata = 32'h77;
      pc = 32'h0; tick();
      pc = 32'h4; tick();
      rf_we = 1'b0; dm_we = 1'b0;
      check("t6_pre_running", running, 1);
      #2 rst = 1'b0;
      #1;
      check("t6_running",  running,  0);
      check("t6_cycles",   cycles,   0);
      check("t6_wb_count", wb_count, 0);
      check("t6_wb_xor",   wb_xor,   0);
      sig_idx = 3'd2; #1;
      check("t6_sig2", sig_data, 0);
      tick();
      rst = 1'b1;
      tick();

      // Rerun after reset: PC held at 0 from the first cycle
      pc = 32'h0;
      start_run();
      for (int i = 0; i < 5; i++) tick();
      check("rerun_done",    done,    1);
      check("rerun_cycles",  cycles,  5);
      check("rerun_halt_pc", halt_pc, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
